// File: rtl/netwalk_flow_stats_pkg.sv
// Shared constants and enums for the netwalk flow statistics engine.
// Counter slots are stored as {pkt, bytes} in a single RAM word.
package netwalk_pkg;

  localparam int TCAM_SIZE       = 64;
  localparam int TCAM_ADDR_WIDTH = 8;
  localparam int PKT_LEN_WIDTH   = 16;
  localparam int PKT_CNT_WIDTH   = 32;
  localparam int BYTE_CNT_WIDTH  = 48;
  localparam int DROP_CNT_WIDTH  = 16;
  localparam int SLOT_W          = $clog2(TCAM_SIZE);
  localparam int ENTRY_W         = PKT_CNT_WIDTH + BYTE_CNT_WIDTH;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_UPD,
    OP_CLR,
    OP_RD
  } op_t;

  typedef struct packed {
    logic [PKT_CNT_WIDTH-1:0]  pkt;
    logic [BYTE_CNT_WIDTH-1:0] bytes;
  } entry_t;

endpackage

// File: rtl/netwalk_flow_stats_if.sv
// Lookup-result, control-plane and status signals of the flow statistics engine.
// master = TCAM core / control plane side, slave = statistics engine.
interface netwalk_flow_stats_if;
  import netwalk_pkg::*;

  logic                       of_flow_found_buff;
  logic                       of_match_found;
  logic                       of_table_missed;
  logic [TCAM_ADDR_WIDTH-1:0] of_matched_decoded_addr_out;
  logic [PKT_LEN_WIDTH-1:0]   pkt_len;

  logic                       stats_clear_enable;
  logic                       stats_rd_req;
  logic [TCAM_ADDR_WIDTH-1:0] stats_ctrl_addr;
  logic                       stats_ctrl_ack;
  logic                       stats_rd_valid;
  logic [PKT_CNT_WIDTH-1:0]   stats_rd_pkt_cnt;
  logic [BYTE_CNT_WIDTH-1:0]  stats_rd_byte_cnt;

  logic [PKT_CNT_WIDTH-1:0]   miss_pkt_cnt;
  logic [DROP_CNT_WIDTH-1:0]  stats_drop_cnt;
  logic                       stats_init_done;

  modport master (
    output of_flow_found_buff, of_match_found, of_table_missed,
           of_matched_decoded_addr_out, pkt_len,
           stats_clear_enable, stats_rd_req, stats_ctrl_addr,
    input  stats_ctrl_ack, stats_rd_valid, stats_rd_pkt_cnt, stats_rd_byte_cnt,
           miss_pkt_cnt, stats_drop_cnt, stats_init_done
  );

  modport slave (
    input  of_flow_found_buff, of_match_found, of_table_missed,
           of_matched_decoded_addr_out, pkt_len,
           stats_clear_enable, stats_rd_req, stats_ctrl_addr,
    output stats_ctrl_ack, stats_rd_valid, stats_rd_pkt_cnt, stats_rd_byte_cnt,
           miss_pkt_cnt, stats_drop_cnt, stats_init_done
  );

endinterface

// File: rtl/netwalk_flow_stats_ram.sv
// Counter storage: 1R1W, registered read (old data on same-address write), no reset.
// Contents are zeroed by the engine's INIT sweep.
module netwalk_flow_stats_ram
  import netwalk_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [SLOT_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [SLOT_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [TCAM_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/netwalk_flow_stats.sv
// Per-flow saturating packet/byte counters behind the TCAM, with global miss and
// drop counters, a control-plane read/clear port and a post-reset zeroing sweep.
module netwalk_flow_stats
  import netwalk_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  netwalk_flow_stats_if.slave  bus
);

  function automatic logic [PKT_CNT_WIDTH-1:0] sat_inc_pkt(input logic [PKT_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + PKT_CNT_WIDTH'(1);
  endfunction

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc_drop(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

  function automatic logic [BYTE_CNT_WIDTH-1:0] sat_add_bytes(
    input logic [BYTE_CNT_WIDTH-1:0] v,
    input logic [PKT_LEN_WIDTH-1:0]  len
  );
    logic [BYTE_CNT_WIDTH:0] sum;
    sum = {1'b0, v} + {{(BYTE_CNT_WIDTH + 1 - PKT_LEN_WIDTH){1'b0}}, len};
    return sum[BYTE_CNT_WIDTH] ? {BYTE_CNT_WIDTH{1'b1}} : sum[BYTE_CNT_WIDTH-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         sweep_idx;
  logic                      run;

  logic                      hit_in_range, ctrl_in_range;
  logic                      upd_req, miss_evt, drop_evt;
  op_t                       op_p0, op_p1;
  logic [SLOT_W-1:0]         slot_p0, slot_p1, slot_p2;
  logic                      rng_p0, rng_p1;
  logic                      ack;
  logic [PKT_LEN_WIDTH-1:0]  len_p1;

  logic [ENTRY_W-1:0]        ram_rdata, ram_wdata;
  logic [SLOT_W-1:0]         ram_waddr;
  logic                      ram_we;
  entry_t                    ram_entry, cur_p1, res_p1, res_p2;
  logic                      wr_p1, wr_p2;

  logic                      rd_vld_q;
  logic [PKT_CNT_WIDTH-1:0]  rd_pkt_q, miss_q;
  logic [BYTE_CNT_WIDTH-1:0] rd_byte_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  // FSM: INIT sweeps every slot once, then RUN forever
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && sweep_idx == SLOT_W'(TCAM_SIZE - 1)) state_d = RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               sweep_idx <= '0;
    else if (state_q == INIT) sweep_idx <= sweep_idx + SLOT_W'(1);
  end

  assign run = (state_q == RUN);

  // Stage p0: classify the lookup event and arbitrate the pipeline slot
  assign hit_in_range  = bus.of_matched_decoded_addr_out < TCAM_ADDR_WIDTH'(TCAM_SIZE);
  assign ctrl_in_range = bus.stats_ctrl_addr < TCAM_ADDR_WIDTH'(TCAM_SIZE);
  assign upd_req  = bus.of_flow_found_buff & ~bus.of_table_missed &
                    bus.of_match_found & hit_in_range & run;
  assign miss_evt = bus.of_flow_found_buff & bus.of_table_missed;
  assign drop_evt = bus.of_flow_found_buff & ~bus.of_table_missed & ~upd_req;

  always_comb begin
    op_p0   = OP_NONE;
    slot_p0 = bus.stats_ctrl_addr[SLOT_W-1:0];
    rng_p0  = ctrl_in_range;
    ack     = 1'b0;
    if (upd_req) begin
      op_p0   = OP_UPD;
      slot_p0 = bus.of_matched_decoded_addr_out[SLOT_W-1:0];
      rng_p0  = 1'b1;
    end else if (run && bus.stats_clear_enable) begin
      op_p0 = OP_CLR;
      ack   = 1'b1;
    end else if (run && bus.stats_rd_req) begin
      op_p0 = OP_RD;
      ack   = 1'b1;
    end
  end

  netwalk_flow_stats_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (slot_p0),
    .rdata (ram_rdata)
  );

  // Stage p1: RAM data arrives; forward the write issued one cycle earlier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) op_p1 <= OP_NONE;
    else        op_p1 <= op_p0;
  end

  always_ff @(posedge clk) begin
    slot_p1 <= slot_p0;
    rng_p1  <= rng_p0;
    len_p1  <= bus.pkt_len;
  end

  assign ram_entry = ram_rdata;

  always_comb begin
    cur_p1 = (wr_p2 && slot_p2 == slot_p1) ? res_p2 : ram_entry;
    res_p1 = cur_p1;
    wr_p1  = 1'b0;
    case (op_p1)
      OP_UPD: begin
        res_p1.pkt   = sat_inc_pkt(cur_p1.pkt);
        res_p1.bytes = sat_add_bytes(cur_p1.bytes, len_p1);
        wr_p1        = 1'b1;
      end
      OP_CLR: begin
        res_p1 = '0;
        wr_p1  = rng_p1;
      end
      default: ;
    endcase
  end

  assign ram_we    = ~run | wr_p1;
  assign ram_waddr = run ? slot_p1 : sweep_idx;
  assign ram_wdata = run ? res_p1 : '0;

  // Stage p2: last written entry kept for forwarding; read data and counters registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_p2 <= 1'b0;
    else        wr_p2 <= wr_p1;
  end

  always_ff @(posedge clk) begin
    slot_p2 <= slot_p1;
    res_p2  <= res_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q  <= 1'b0;
      rd_pkt_q  <= '0;
      rd_byte_q <= '0;
    end else begin
      rd_vld_q <= (op_p1 == OP_RD);
      if (op_p1 == OP_RD) begin
        rd_pkt_q  <= rng_p1 ? cur_p1.pkt   : '0;
        rd_byte_q <= rng_p1 ? cur_p1.bytes : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_q <= '0;
      drop_q <= '0;
    end else begin
      if (miss_evt) miss_q <= sat_inc_pkt(miss_q);
      if (drop_evt) drop_q <= sat_inc_drop(drop_q);
    end
  end

  assign bus.stats_ctrl_ack    = ack;
  assign bus.stats_rd_valid    = rd_vld_q;
  assign bus.stats_rd_pkt_cnt  = rd_pkt_q;
  assign bus.stats_rd_byte_cnt = rd_byte_q;
  assign bus.miss_pkt_cnt      = miss_q;
  assign bus.stats_drop_cnt    = drop_q;
  assign bus.stats_init_done   = run;

endmodule

// File: tb/tb_netwalk_flow_stats.sv
// Directed bench for netwalk_flow_stats: init sweep timing, forwarding, drops,
// misses, saturation, clear/read arbitration against updates, and mid-stream reset.
module tb_netwalk_flow_stats;
  import netwalk_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   n;

  netwalk_flow_stats_if bus();

  netwalk_flow_stats dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic match, input logic missed,
                        input logic [7:0] addr, input logic [15:0] len);
    bus.of_flow_found_buff          = 1'b1;
    bus.of_match_found              = match;
    bus.of_table_missed             = missed;
    bus.of_matched_decoded_addr_out = addr;
    bus.pkt_len                     = len;
    @(posedge clk); #1;
    bus.of_flow_found_buff = 1'b0;
    bus.of_match_found     = 1'b0;
    bus.of_table_missed    = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.stats_ctrl_ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(bus.stats_ctrl_ack), 64'd1);
  endtask

  task automatic ctrl_clear(input logic [7:0] addr);
    bus.stats_clear_enable = 1'b1;
    bus.stats_ctrl_addr    = addr;
    wait_ack("clr_ack");
    @(posedge clk); #1;
    bus.stats_clear_enable = 1'b0;
  endtask

  task automatic ctrl_read(input string tag, input logic [7:0] addr,
                           input logic [31:0] exp_pkt, input logic [47:0] exp_byte);
    bus.stats_rd_req    = 1'b1;
    bus.stats_ctrl_addr = addr;
    wait_ack({tag, "_ack"});
    @(posedge clk); #1;
    bus.stats_rd_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_vld"},  64'(bus.stats_rd_valid),    64'd1);
    check({tag, "_pkt"},  64'(bus.stats_rd_pkt_cnt),  64'(exp_pkt));
    check({tag, "_byte"}, 64'(bus.stats_rd_byte_cnt), 64'(exp_byte));
  endtask

  // Counts cycles from reset release to init_done; optionally injects a hit at
  // cycle 10 and a miss at cycle 11 of the sweep.
  task automatic wait_init(input logic inject, output int cycles);
    cycles = 0;
    while (!bus.stats_init_done && cycles < 200) begin
      bus.of_flow_found_buff          = inject && (cycles == 10 || cycles == 11);
      bus.of_match_found              = (cycles == 10);
      bus.of_table_missed             = (cycles == 11);
      bus.of_matched_decoded_addr_out = 8'd3;
      bus.pkt_len                     = 16'd50;
      @(posedge clk); #1;
      cycles++;
    end
    bus.of_flow_found_buff = 1'b0;
    bus.of_match_found     = 1'b0;
    bus.of_table_missed    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  64'(bus.stats_ctrl_ack),    64'd0);
    check({tag, "_vld"},  64'(bus.stats_rd_valid),    64'd0);
    check({tag, "_pkt"},  64'(bus.stats_rd_pkt_cnt),  64'd0);
    check({tag, "_byte"}, 64'(bus.stats_rd_byte_cnt), 64'd0);
    check({tag, "_miss"}, 64'(bus.miss_pkt_cnt),      64'd0);
    check({tag, "_drop"}, 64'(bus.stats_drop_cnt),    64'd0);
    check({tag, "_done"}, 64'(bus.stats_init_done),   64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.of_flow_found_buff          = 1'b0;
    bus.of_match_found              = 1'b0;
    bus.of_table_missed             = 1'b0;
    bus.of_matched_decoded_addr_out = '0;
    bus.pkt_len                     = '0;
    bus.stats_clear_enable          = 1'b0;
    bus.stats_rd_req                = 1'b0;
    bus.stats_ctrl_addr             = '0;

    // reset state, with a read request held to show no ack in reset
    repeat (3) @(posedge clk);
    #1;
    bus.stats_rd_req = 1'b1;
    #1;
    check_all_zero("rst");
    bus.stats_rd_req = 1'b0;

    @(posedge clk); #1;
    reset = 1'b1;
    wait_init(1'b0, n);
    check("init_cycles", 64'(n), 64'd64);
    check("init_done", 64'(bus.stats_init_done), 64'd1);
    ctrl_read("rd5", 8'd5, 32'd0, 48'd0);

    // back-to-back hits on slot 3, then an immediate read
    lookup(1'b1, 1'b0, 8'd3, 16'd64);
    lookup(1'b1, 1'b0, 8'd3, 16'd1500);
    ctrl_read("rd3_fwd", 8'd3, 32'd2, 48'd1564);

    // out-of-range hit: dropped, aliasing slot untouched
    lookup(1'b1, 1'b0, 8'd70, 16'd10);
    check("drop_oor", 64'(bus.stats_drop_cnt), 64'd1);
    ctrl_read("rd70", 8'd70, 32'd0, 48'd0);
    ctrl_read("rd6", 8'd6, 32'd0, 48'd0);

    // misses; the last also carries a hit flag which must be ignored
    lookup(1'b0, 1'b1, 8'd0, 16'd40);
    lookup(1'b0, 1'b1, 8'd0, 16'd40);
    lookup(1'b1, 1'b1, 8'd3, 16'd40);
    check("miss3", 64'(bus.miss_pkt_cnt), 64'd3);
    lookup(1'b0, 1'b0, 8'd3, 16'd40);
    check("drop_noflag", 64'(bus.stats_drop_cnt), 64'd2);
    check("miss_hold", 64'(bus.miss_pkt_cnt), 64'd3);

    // clear to an aliasing out-of-range address has no effect
    ctrl_clear(8'd67);
    ctrl_read("rd3_keep", 8'd3, 32'd2, 48'd1564);

    // packet counter saturation from a preloaded slot
    dut.u_ram.mem[9] <= {32'hFFFF_FFFE, 48'd100};
    @(posedge clk); #1;
    lookup(1'b1, 1'b0, 8'd9, 16'd1);
    lookup(1'b1, 1'b0, 8'd9, 16'd2);
    lookup(1'b1, 1'b0, 8'd9, 16'd3);
    ctrl_read("rd9_sat", 8'd9, 32'hFFFF_FFFF, 48'd106);

    // byte counter saturation
    dut.u_ram.mem[10] <= {32'd5, 48'hFFFF_FFFF_FF00};
    @(posedge clk); #1;
    lookup(1'b1, 1'b0, 8'd10, 16'h0200);
    ctrl_read("rd10_sat", 8'd10, 32'd6, 48'hFFFF_FFFF_FFFF);

    // clear + read of slot 3 held together against a hit stream every other cycle
    bus.stats_clear_enable          = 1'b1;
    bus.stats_rd_req                = 1'b1;
    bus.stats_ctrl_addr             = 8'd3;
    bus.of_flow_found_buff          = 1'b1;
    bus.of_match_found              = 1'b1;
    bus.of_matched_decoded_addr_out = 8'd3;
    bus.pkt_len                     = 16'd10;
    @(negedge clk);
    check("arb_c0_noack", 64'(bus.stats_ctrl_ack), 64'd0);
    @(posedge clk); #1;
    bus.of_flow_found_buff = 1'b0;
    @(negedge clk);
    check("arb_c1_clrack", 64'(bus.stats_ctrl_ack), 64'd1);
    @(posedge clk); #1;
    bus.stats_clear_enable = 1'b0;
    bus.of_flow_found_buff = 1'b1;
    bus.pkt_len            = 16'd20;
    @(negedge clk);
    check("arb_c2_noack", 64'(bus.stats_ctrl_ack), 64'd0);
    @(posedge clk); #1;
    bus.of_flow_found_buff = 1'b0;
    @(negedge clk);
    check("arb_c3_rdack", 64'(bus.stats_ctrl_ack), 64'd1);
    @(posedge clk); #1;
    bus.stats_rd_req       = 1'b0;
    bus.of_flow_found_buff = 1'b1;
    bus.pkt_len            = 16'd40;
    @(negedge clk);
    check("arb_c4_novld", 64'(bus.stats_rd_valid), 64'd0);
    @(posedge clk); #1;
    bus.of_flow_found_buff = 1'b0;
    bus.of_match_found     = 1'b0;
    check("arb_c5_vld",  64'(bus.stats_rd_valid),    64'd1);
    check("arb_c5_pkt",  64'(bus.stats_rd_pkt_cnt),  64'd1);
    check("arb_c5_byte", 64'(bus.stats_rd_byte_cnt), 64'd20);
    @(posedge clk); #1;
    check("arb_c6_vld",  64'(bus.stats_rd_valid),    64'd0);
    check("arb_c6_hold", 64'(bus.stats_rd_pkt_cnt),  64'd1);
    ctrl_read("rd3_after", 8'd3, 32'd2, 48'd60);

    // asynchronous reset in the middle of a lookup stream
    bus.of_flow_found_buff          = 1'b1;
    bus.of_match_found              = 1'b1;
    bus.of_matched_decoded_addr_out = 8'd3;
    bus.pkt_len                     = 16'd77;
    bus.stats_rd_req                = 1'b1;
    bus.stats_ctrl_addr             = 8'd3;
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bus.of_flow_found_buff = 1'b0;
    bus.of_match_found     = 1'b0;
    bus.stats_rd_req       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_init(1'b1, n);
    check("reinit_cycles", 64'(n), 64'd64);
    check("init_drop", 64'(bus.stats_drop_cnt), 64'd1);
    check("init_miss", 64'(bus.miss_pkt_cnt), 64'd1);
    ctrl_read("rd3_reinit", 8'd3, 32'd0, 48'd0);
    ctrl_read("rd9_reinit", 8'd9, 32'd0, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
